operate_cmd_receiver: RTL and testbench
=======================================

OPERATE_CMD_RECEIVER -- requirements
Module: operate_cmd_receiver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter LW, default 3, level width, equal to log2(DEPTH)+1.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port data  input  8  command frame from the traveler operate machine; [1:0] tag, [6:2] one-hot op, [7] don't care.
REQ-006 SHALL have port op_ready  input  1  consumer accepts the head entry this cycle.
REQ-007 SHALL have port clr  input  1  synchronous clear of overflow and err_cnt.
REQ-008 SHALL have port op_valid  output  1  FIFO non-empty; op_code is valid.
REQ-009 SHALL have port op_code  output  5  one-hot head op: [0] get, [1] put, [2] interact, [3] move, [4] throw.
REQ-010 SHALL have port level  output  LW  current FIFO occupancy, 0..DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky: a valid command was dropped.
REQ-012 SHALL have port err_cnt  output  8  saturating count of malformed frames.

Function
REQ-013 SHALL register data into an input stage every clock, with no other qualification.
REQ-014 SHALL classify the registered frame f as follows:
- NULL: f[1:0]==2'b10 and f[6:2]==0; ignored.
- VALID: f[1:0]==2'b10 and f[6:2] has exactly one bit set.
- MALFORMED: anything else.
REQ-015 SHALL ignore f[7] in every classification.
REQ-016 SHALL write a VALID f[6:2] into the FIFO on the edge after it is registered.
- Input-to-op_valid latency: 2 edges when the FIFO is empty.
- No combinational bypass.
REQ-017 SHALL treat each cycle holding a VALID frame as one command; a frame held for N cycles yields N entries.
REQ-018 SHALL pop the head on an edge where op_valid and op_ready are both 1.
REQ-019 SHALL ignore op_ready while op_valid is 0.
REQ-020 SHALL keep op_code stable while op_valid=1 and op_ready=0.
REQ-021 SHALL drive op_code to 0 when the FIFO is empty.
REQ-022 SHALL handle a push while full as follows:
- Accept the push if a pop occurs on the same edge; level is unchanged.
- Otherwise drop the command and set overflow.
REQ-023 SHALL perform simultaneous push and pop when empty as a push only.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL increment err_cnt by 1 per MALFORMED frame and saturate at 255.
REQ-026 SHALL give clr priority over a same-edge err_cnt increment or overflow set; clr SHALL NOT affect FIFO contents.

Reset
REQ-027 SHALL asynchronously drive the following while rst_n=0:
- op_valid=0, op_code=0, level=0, overflow=0, err_cnt=0.
- Input stage = 8'b0000_0010 (NULL).
- Pointers = 0.
REQ-028 SHALL discard FIFO contents and any in-flight frame on reset mid-operation.
REQ-029 SHALL treat the first frame sampled after rst_n rises normally.

Configuration
REQ-030 SHALL, when macro OPCMD_ERRCNT_EN is defined, implement the err_cnt counter per REQ-025.
REQ-031 SHALL, when OPCMD_ERRCNT_EN is undefined, tie err_cnt to 0 and still drop MALFORMED frames.

Verification
REQ-032 SHALL verify basic path: data=8'b0_01000_10 for 1 cycle, op_ready=0 -> op_valid=1 two edges later, op_code=5'b01000, level=1.
REQ-033 SHALL verify fill and overflow: 5 VALID frames (get, put, interact, move, throw), op_ready=0, DEPTH=4 -> level=4, overflow=1; pops yield 00001, 00010, 00100, 01000.
REQ-034 SHALL verify full-with-pop: FIFO full, op_ready=1, VALID put frame -> level stays 4, overflow stays 0, tail=00010.
REQ-035 SHALL verify malformed frames: 8'b0_00011_10, then 8'b0_00001_01, then 8'b1_00000_10 -> err_cnt=2, level=0; 300 malformed frames -> err_cnt=255; clr -> 0.
REQ-036 SHALL verify reset mid-operation: level=3, rst_n low for 1 cycle -> op_valid=0, level=0, op_code=0 immediately, without waiting for a clock edge.
REQ-037 SHALL verify build without OPCMD_ERRCNT_EN: repeat REQ-035 stimulus -> err_cnt=0 throughout, level=0.

Source files
------------

// File: rtl/operate_cmd_receiver.sv
// ----------------------------------------------------------------------------
// operate_cmd_receiver
//
// Receives 8-bit command frames from the traveler operate machine, filters
// them and queues the one-hot operation codes in a small FIFO for a
// downstream consumer.
//
// Frame layout: [1:0] tag, [6:2] one-hot op, [7] ignored.
//   NULL      : tag==2'b10, op==0            -> ignored
//   VALID     : tag==2'b10, op exactly one-hot -> queued
//   MALFORMED : anything else                -> dropped, counted
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   data      in   [7:0] command frame, registered every clock
//   op_ready  in   consumer accepts the head entry this cycle
//   clr       in   synchronous clear of overflow and err_cnt
//   op_valid  out  FIFO non-empty
//   op_code   out  [4:0] head op (get, put, interact, move, throw); 0 if empty
//   level     out  [LW-1:0] FIFO occupancy 0..DEPTH
//   overflow  out  sticky: a VALID command was dropped on a full FIFO
//   err_cnt   out  [7:0] saturating count of MALFORMED frames
//
// Handshake: the head entry leaves the FIFO on a rising edge where
// op_valid and op_ready are both 1; op_ready is ignored while op_valid is 0,
// and op_code holds steady while op_valid=1 and op_ready=0.
//
// Build option: define OPCMD_ERRCNT_EN to implement err_cnt; otherwise
// err_cnt is tied to 0 (MALFORMED frames are still dropped).
// ----------------------------------------------------------------------------
module operate_cmd_receiver #(
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    data,
    input  logic          op_ready,
    input  logic          clr,
    output logic          op_valid,
    output logic [4:0]    op_code,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic [7:0]    err_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Input stage; resets to a NULL frame so nothing is queued out of reset.
    logic [7:0]    frame_q;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [4:0]    mem_q [DEPTH];

    logic [4:0]    frame_op;
    logic          tag_ok;
    logic          op_onehot;
    logic          frame_valid;
    logic          frame_null;
    logic          frame_malformed;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push_acc;
    logic          drop;

    // ------------------------------------------------------------------
    // Frame classification (bit 7 takes no part)
    // ------------------------------------------------------------------
    always_comb begin
        frame_op        = frame_q[6:2];
        tag_ok          = (frame_q[1:0] == 2'b10);
        // x & (x-1) clears the lowest set bit; zero result means one bit set.
        op_onehot       = (frame_op != 5'd0) &&
                          ((frame_op & (frame_op - 5'd1)) == 5'd0);
        frame_valid     = tag_ok && op_onehot;
        frame_null      = tag_ok && (frame_op == 5'd0);
        frame_malformed = !frame_valid && !frame_null;
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == LW'(DEPTH));
    // An empty FIFO cannot pop, so push+pop on empty degenerates to push.
    assign pop        = !fifo_empty && op_ready;
    // A full FIFO still takes the push when the head leaves on the same edge.
    assign push_acc   = frame_valid && (!fifo_full || pop);
    assign drop       = frame_valid && fifo_full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        // Pointers are PW bits wide and DEPTH is a power of two, so the
        // increment wraps modulo DEPTH on its own.
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push_acc, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase

        if (clr) begin
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q    <= 8'b0000_0010;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            frame_q    <= data;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: an entry is only visible while count_q covers it.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= frame_op;
        end
    end

    assign op_valid = !fifo_empty;
    assign op_code  = fifo_empty ? 5'd0 : mem_q[rd_ptr_q];
    assign level    = count_q;
    assign overflow = overflow_q;

    // ------------------------------------------------------------------
    // Malformed-frame counter
    // ------------------------------------------------------------------
`ifdef OPCMD_ERRCNT_EN
    logic [7:0] err_q, err_d;
    logic       unused_bits;

    always_comb begin
        err_d = err_q;
        if (clr) begin
            err_d = 8'd0;
        end else if (frame_malformed && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt     = err_q;
    assign unused_bits = frame_q[7];
`else
    logic unused_bits;

    assign err_cnt     = 8'd0;
    assign unused_bits = ^{frame_q[7], frame_malformed};
`endif

endmodule

// File: tb/tb_operate_cmd_receiver.sv
// ----------------------------------------------------------------------------
// Testbench for operate_cmd_receiver.
// A queue-based reference model advances on each rising edge; a monitor on
// the falling edge compares every DUT output against it.
// ----------------------------------------------------------------------------
module tb_operate_cmd_receiver;

    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk;
    logic          rst_n;
    logic [7:0]    data;
    logic          op_ready;
    logic          clr;
    logic          op_valid;
    logic [4:0]    op_code;
    logic [LW-1:0] level;
    logic          overflow;
    logic [7:0]    err_cnt;

    int vectors;
    int miscompares;

    operate_cmd_receiver #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data),
        .op_ready (op_ready),
        .clr      (clr),
        .op_valid (op_valid),
        .op_code  (op_code),
        .level    (level),
        .overflow (overflow),
        .err_cnt  (err_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [4:0] exp_q[$];
    logic [7:0] pend;
    bit         exp_ovf;
    int         exp_err;
    bit         m_pop;
    bit         m_drop;
    int         m_cls;

    // 0 = NULL, 1 = VALID, 2 = MALFORMED
    function automatic int classify(input logic [7:0] f);
        logic [4:0] op;
        op = f[6:2];
        if (f[1:0] != 2'b10) return 2;
        if (op == 5'd0) return 0;
        if ($countones(op) == 1) return 1;
        return 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            pend    = 8'b0000_0010;
            exp_ovf = 1'b0;
            exp_err = 0;
        end else begin
            m_pop  = (exp_q.size() > 0) && op_ready;
            m_cls  = classify(pend);
            m_drop = 1'b0;
            if (m_pop) void'(exp_q.pop_front());
            if (m_cls == 1) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(pend[6:2]);
                else m_drop = 1'b1;
            end
            if (clr) exp_ovf = 1'b0;
            else if (m_drop) exp_ovf = 1'b1;
`ifdef OPCMD_ERRCNT_EN
            if (clr) exp_err = 0;
            else if (m_cls == 2 && exp_err < 255) exp_err = exp_err + 1;
`endif
            pend = data;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input int act, input int req);
        vectors = vectors + 1;
        if (act != req) begin
            miscompares = miscompares + 1;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        check("op_valid", int'(op_valid), (exp_q.size() != 0) ? 1 : 0);
        check("op_code",  int'(op_code),  (exp_q.size() != 0) ? int'(exp_q[0]) : 0);
        check("level",    int'(level),    exp_q.size());
        check("overflow", int'(overflow), int'(exp_ovf));
        check("err_cnt",  int'(err_cnt),  exp_err);
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [7:0] d, input logic r, input logic c);
        data     = d;
        op_ready = r;
        clr      = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) drive(8'b0_00000_10, r, 1'b0);
    endtask

    function automatic logic [7:0] vframe(input int bitpos, input logic b7);
        logic [4:0] op;
        op = 5'd1 << bitpos;
        return {b7, op, 2'b10};
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        data        = 8'b0000_0010;
        op_ready    = 1'b0;
        clr         = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic path: single move frame.
        drive(8'b0_01000_10, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(2, 1'b1);

        // Fill and overflow: get, put, interact, move, throw.
        for (int i = 0; i < 5; i++) drive(vframe(i, 1'b0), 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(5, 1'b1);
        drive(8'b0_00000_10, 1'b0, 1'b1);

        // Full with simultaneous pop.
        for (int i = 0; i < 4; i++) drive(vframe(4 - i, 1'b1), 1'b0, 1'b0);
        idle(2, 1'b0);
        drive(vframe(1, 1'b0), 1'b0, 1'b0);
        drive(8'b0_00000_10, 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(5, 1'b1);

        // Malformed frames, saturation, clear.
        drive(8'b0_00011_10, 1'b0, 1'b0);
        drive(8'b0_00001_01, 1'b0, 1'b0);
        drive(8'b1_00000_10, 1'b0, 1'b0);
        idle(2, 1'b0);
        for (int i = 0; i < 300; i++) drive(8'b0_00011_10, 1'b0, 1'b0);
        idle(2, 1'b0);
        drive(8'b0_00000_10, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Reset mid-operation with level 3.
        for (int i = 0; i < 3; i++) drive(vframe(i, 1'b0), 1'b0, 1'b0);
        idle(2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_op_valid", int'(op_valid), 0);
        check("rst_level",    int'(level),    0);
        check("rst_op_code",  int'(op_code),  0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(vframe(2, 1'b0), 1'b0, 1'b0);
        idle(3, 1'b1);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            int          r;
            logic [7:0]  d;
            r = $urandom_range(0, 9);
            if (r < 6)       d = vframe($urandom_range(0, 4), 1'($urandom_range(0, 1)));
            else if (r == 6) d = {1'($urandom_range(0, 1)), 5'd0, 2'b10};
            else             d = 8'($urandom_range(0, 255));
            drive(d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
        end
        idle(8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
